// File: rtl/tick_countdown_pkg.sv
// Shared types, limits and the time-update arithmetic for the race countdown.
package tick_countdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } countdown_state_t;

    localparam logic [6:0] MAX_MIN = 7'd99;
    localparam logic [5:0] MAX_SEC = 6'd59;

    typedef struct packed {
        logic [6:0] mins;
        logic [5:0] secs;
    } race_time_t;

    // Decrement by one second (if requested), then add the bonus with carry
    // into minutes, saturating at 99:59. Decrementing 00:00 leaves it at 00:00.
    function automatic race_time_t update_time(
        input logic [6:0] mins,
        input logic [5:0] secs,
        input logic       doDec,
        input logic       doAdd,
        input logic [5:0] bonus
    );
        logic [7:0] m;
        logic [6:0] s;
        race_time_t result;
        m = {1'b0, mins};
        s = {1'b0, secs};
        if (doDec) begin
            if (s != 7'd0) begin
                s = s - 7'd1;
            end else if (m != 8'd0) begin
                m = m - 8'd1;
                s = 7'd59;
            end
        end
        if (doAdd) begin
            s = s + {1'b0, bonus};
            if (s >= 7'd60) begin
                s = s - 7'd60;
                m = m + 8'd1;
            end
            if (m > {1'b0, MAX_MIN}) begin
                m = {1'b0, MAX_MIN};
                s = {1'b0, MAX_SEC};
            end
        end
        result.mins = m[6:0];
        result.secs = s[5:0];
        return result;
    endfunction

endpackage

// File: rtl/tick_countdown_bin2bcd99.sv
// Combinational split of a 0..99 binary value into tens and ones BCD digits.
module bin2bcd99 (
    input  logic [6:0] i_bin,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones
);

    // Constant divisor keeps this a small comparator/subtractor network.
    always_comb begin
        o_tens = 4'(i_bin / 7'd10);
        o_ones = 4'(i_bin % 7'd10);
    end

endmodule

// File: rtl/tick_countdown.sv
// Race countdown: holds remaining MM:SS, counts down on game-second ticks,
// handles load/start/pause/bonus and drives BCD digits plus low-time blink.
module tick_countdown
    import tick_countdown_pkg::*;
#(
    parameter int unsigned START_MIN = 1,
    parameter int unsigned START_SEC = 30,
    parameter int unsigned BONUS_SEC = 10,
    parameter int unsigned WARN_SEC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       blink_in,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic       add_bonus,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       time_up,
    output logic       expired,
    output logic       warn,
    output logic       display_en
);

    localparam logic [6:0] LOAD_MIN = 7'(START_MIN);
    localparam logic [5:0] LOAD_SEC = 6'(START_SEC);
    localparam logic [5:0] BONUS    = 6'(BONUS_SEC);
    localparam logic [5:0] WARN_LIM = 6'(WARN_SEC);

    countdown_state_t r_state;
    countdown_state_t w_nextState;
    logic [6:0]       r_mins;
    logic [5:0]       r_secs;
    logic             r_expired;
    logic [6:0]       w_nextMins;
    logic [5:0]       w_nextSecs;
    logic             w_nextExpired;
    logic             w_tickCounted;
    logic             w_bonusOk;
    race_time_t       w_upd;
    logic             w_lowTime;

    // Ticks count only while already running; a bonus is refused once expired.
    assign w_tickCounted = (r_state == RUN) && tick;
    assign w_bonusOk     = add_bonus && (r_state != DONE);
    assign w_upd         = update_time(r_mins, r_secs, w_tickCounted, w_bonusOk, BONUS);

    // Next state/time: load overrides everything, otherwise apply the merged update.
    always_comb begin
        w_nextState   = r_state;
        w_nextMins    = r_mins;
        w_nextSecs    = r_secs;
        w_nextExpired = 1'b0;
        if (load) begin
            w_nextState = IDLE;
            w_nextMins  = LOAD_MIN;
            w_nextSecs  = LOAD_SEC;
        end else begin
            if (r_state != DONE) begin
                w_nextMins = w_upd.mins;
                w_nextSecs = w_upd.secs;
            end
            case (r_state)
                IDLE, PAUSED: begin
                    if (start) begin
                        w_nextState = RUN;
                    end
                end
                RUN: begin
                    if (w_tickCounted && !add_bonus &&
                        (w_upd.mins == 7'd0) && (w_upd.secs == 6'd0)) begin
                        w_nextState   = DONE;
                        w_nextExpired = 1'b1;
                    end else if (pause) begin
                        w_nextState = PAUSED;
                    end
                end
                default: begin
                    w_nextState = r_state;
                end
            endcase
        end
    end

    // State, time and the expiry pulse register; reset reloads the start time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_mins    <= LOAD_MIN;
            r_secs    <= LOAD_SEC;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_mins    <= w_nextMins;
            r_secs    <= w_nextSecs;
            r_expired <= w_nextExpired;
        end
    end

    bin2bcd99 u_minDigits (
        .i_bin  (r_mins),
        .o_tens (min_tens),
        .o_ones (min_ones)
    );

    bin2bcd99 u_secDigits (
        .i_bin  ({1'b0, r_secs}),
        .o_tens (sec_tens),
        .o_ones (sec_ones)
    );

    assign w_lowTime  = (r_mins == 7'd0) && (r_secs != 6'd0) && (r_secs <= WARN_LIM);
    assign warn       = w_lowTime && ((r_state == RUN) || (r_state == PAUSED));
    assign display_en = !(warn && !blink_in);
    assign running    = (r_state == RUN);
    assign time_up    = (r_state == DONE);
    assign expired    = r_expired;

endmodule

// File: tb/tb_tick_countdown.sv
// Directed bench for tick_countdown: full countdown, expiry, bonus/tick merge,
// pause/resume edge cases, async reset abort and bonus saturation.
module tb_tick_countdown;

    logic clk = 1'b0;
    logic reset, tick, blink_in, load, start, pause, add_bonus;
    logic [3:0] minTens, minOnes, secTens, secOnes;
    logic running, timeUp, expired, warn, displayEn;
    logic [3:0] d2MinTens, d2MinOnes, d2SecTens, d2SecOnes;
    logic d2Running, d2TimeUp, d2Expired, d2Warn, d2DisplayEn;

    int numCompared = 0;
    int numMismatched = 0;

    always #5 clk = ~clk;

    tick_countdown dut (
        .clk(clk), .reset(reset), .tick(tick), .blink_in(blink_in),
        .load(load), .start(start), .pause(pause), .add_bonus(add_bonus),
        .min_tens(minTens), .min_ones(minOnes), .sec_tens(secTens), .sec_ones(secOnes),
        .running(running), .time_up(timeUp), .expired(expired),
        .warn(warn), .display_en(displayEn)
    );

    tick_countdown #(.START_MIN(99), .START_SEC(55)) dutSat (
        .clk(clk), .reset(reset), .tick(tick), .blink_in(blink_in),
        .load(load), .start(start), .pause(pause), .add_bonus(add_bonus),
        .min_tens(d2MinTens), .min_ones(d2MinOnes), .sec_tens(d2SecTens), .sec_ones(d2SecOnes),
        .running(d2Running), .time_up(d2TimeUp), .expired(d2Expired),
        .warn(d2Warn), .display_en(d2DisplayEn)
    );

    // Single comparison point: counts and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] bcdOf(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic checkTime(input string tag, input int m, input int s);
        checkOutput(tag, {16'd0, minTens, minOnes, secTens, secOnes}, {16'd0, bcdOf(m, s)});
    endtask

    // Drive one cycle of pulses, let the edge sample them, then clear.
    task automatic applyStimulus(input logic tk, input logic st, input logic ps,
                                 input logic ld, input logic bn);
        tick = tk; start = st; pause = ps; load = ld; add_bonus = bn;
        @(posedge clk);
        #1;
        tick = 1'b0; start = 1'b0; pause = 1'b0; load = 1'b0; add_bonus = 1'b0;
    endtask

    initial begin
        int rem;
        reset = 1'b1; tick = 0; blink_in = 1'b1; load = 0; start = 0; pause = 0; add_bonus = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        checkTime("reset_time", 1, 30);
        checkOutput("reset_running", 32'(running), 32'd0);
        checkOutput("reset_time_up", 32'(timeUp), 32'd0);
        checkOutput("reset_expired", 32'(expired), 32'd0);
        checkOutput("reset_warn", 32'(warn), 32'd0);
        checkOutput("reset_display_en", 32'(displayEn), 32'd1);

        // Start (with a same-cycle tick that must not count), then 90 back-to-back ticks.
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("start_running", 32'(running), 32'd1);
        checkTime("start_tick_ignored", 1, 30);
        for (int n = 1; n <= 90; n++) begin
            applyStimulus(1, 0, 0, 0, 0);
            rem = 90 - n;
            checkTime($sformatf("count_%0d", n), rem / 60, rem % 60);
            if (n == 90) begin
                checkOutput("expired_pulse", 32'(expired), 32'd1);
                checkOutput("done_time_up", 32'(timeUp), 32'd1);
                checkOutput("done_running", 32'(running), 32'd0);
                checkOutput("done_warn", 32'(warn), 32'd0);
            end else begin
                checkOutput($sformatf("expired_low_%0d", n), 32'(expired), 32'd0);
                checkOutput($sformatf("warn_%0d", n), 32'(warn), (rem <= 10) ? 32'd1 : 32'd0);
            end
            if (rem == 5) begin
                blink_in = 1'b0; #1;
                checkOutput("display_blink_low", 32'(displayEn), 32'd0);
                blink_in = 1'b1; #1;
                checkOutput("display_blink_high", 32'(displayEn), 32'd1);
            end
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("expired_one_cycle", 32'(expired), 32'd0);
        checkOutput("time_up_held", 32'(timeUp), 32'd1);

        // DONE ignores bonus and start; load brings it back to IDLE.
        applyStimulus(1, 1, 0, 0, 1);
        checkTime("done_bonus_ignored", 0, 0);
        checkOutput("done_start_ignored", 32'(timeUp), 32'd1);
        applyStimulus(0, 0, 0, 1, 0);
        checkTime("load_time", 1, 30);
        checkOutput("load_time_up", 32'(timeUp), 32'd0);
        checkOutput("load_running", 32'(running), 32'd0);

        // Run to 00:01, then tick plus bonus lands on 00:10 without expiring.
        applyStimulus(0, 1, 0, 0, 0);
        repeat (89) applyStimulus(1, 0, 0, 0, 0);
        checkTime("at_one_sec", 0, 1);
        applyStimulus(1, 0, 0, 0, 1);
        checkTime("tick_bonus_merge", 0, 10);
        checkOutput("tick_bonus_running", 32'(running), 32'd1);
        checkOutput("tick_bonus_no_expire", 32'(expired), 32'd0);

        // Pause with a coincident tick counts it; paused ticks are dropped.
        applyStimulus(1, 0, 1, 0, 0);
        checkTime("pause_tick_counted", 0, 9);
        checkOutput("paused_running", 32'(running), 32'd0);
        applyStimulus(1, 0, 0, 0, 0);
        checkTime("paused_tick_ignored", 0, 9);
        checkOutput("paused_warn", 32'(warn), 32'd1);
        applyStimulus(1, 1, 0, 0, 0);
        checkTime("resume_tick_ignored", 0, 9);
        checkOutput("resume_running", 32'(running), 32'd1);
        repeat (4) applyStimulus(1, 0, 0, 0, 0);
        checkTime("before_reset", 0, 5);

        // Asynchronous reset mid-count aborts with no expiry pulse.
        reset = 1'b1;
        #1;
        checkTime("async_reset_time", 1, 30);
        checkOutput("async_reset_running", 32'(running), 32'd0);
        checkOutput("async_reset_expired", 32'(expired), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("after_reset_time_up", 32'(timeUp), 32'd0);

        // Bonus in IDLE: 01:30 -> 01:40 on the default unit, 99:55 saturates at 99:59.
        checkOutput("sat_start", 32'({d2MinTens, d2MinOnes, d2SecTens, d2SecOnes}), 32'(bcdOf(99, 55)));
        applyStimulus(0, 0, 0, 0, 1);
        checkTime("idle_bonus", 1, 40);
        checkOutput("sat_bonus", 32'({d2MinTens, d2MinOnes, d2SecTens, d2SecOnes}), 32'(bcdOf(99, 59)));
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("sat_hold", 32'({d2MinTens, d2MinOnes, d2SecTens, d2SecOnes}), 32'(bcdOf(99, 59)));
        checkOutput("sat_idle_running", 32'(d2Running), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
